// File: rtl/sd_spi_cmd_resp_if.sv
// Command/response handshake between the SD init/read controller (master)
// and the SPI command engine (slave).
interface sd_spi_cmd_resp_if;
   logic [5:0]  index;
   logic [31:0] argument;
   logic        start;
   logic        busy;
   logic        finish;
   logic        timeout;
   logic [39:0] response;

   modport master (
      output index, argument, start,
      input  busy, finish, timeout, response
   );

   modport slave (
      input  index, argument, start,
      output busy, finish, timeout, response
   );
endinterface

// File: rtl/sd_spi_cmd_resp.sv
// SPI-mode SD command engine: sends one 48-bit command frame on DI and captures the R1/R3/R7 reply from DO.
// SD_CRC7_EN: when defined, CRC7 is generated serially; otherwise a fixed CMD0/CMD8 table is used.
//
// state  | meaning
// IDLE   | waiting for start; DI high
// PRE    | PRE_IDLE clocks of DI high before the frame
// SEND   | 48 frame bits, MSB first
// WAIT   | DI high, hunting DO for the response start bit
// RECV   | shifting in the rest of the response
// DONE   | finish high until start drops
module sd_spi_cmd_resp #(
   parameter int PRE_IDLE     = 8,
   parameter int RESP_TIMEOUT = 100
) (
   input  logic               clk,
   input  logic               reset_n,
   sd_spi_cmd_resp_if.slave   cmd,
   output logic               DI,
   input  logic               DO
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PRE  = 3'd1;
   localparam logic [2:0] S_SEND = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_RECV = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam int CNT_W = $clog2(RESP_TIMEOUT + PRE_IDLE + 48);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [39:0]      tx_q, tx_d;
   logic [6:0]       crc_q, crc_d;
   logic             long_q, long_d;
   logic [39:0]      shift_q, shift_d;
   logic [39:0]      resp_q, resp_d;
   logic             timeout_q, timeout_d;
   logic             send_bit;

`ifdef SD_CRC7_EN
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction
`else
   function automatic logic [6:0] crc7_table(input logic [5:0] idx);
      case (idx)
         6'd0:    return 7'h4A;
         6'd8:    return 7'h43;
         default: return 7'h7F;
      endcase
   endfunction
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tx_d      = tx_q;
      crc_d     = crc_q;
      long_d    = long_q;
      shift_d   = shift_q;
      resp_d    = resp_q;
      timeout_d = timeout_q;
      case (state_q)
         S_IDLE: begin
            if (cmd.start) begin
               tx_d      = {2'b01, cmd.index, cmd.argument};
               long_d    = (cmd.index == 6'd8) || (cmd.index == 6'd58);
`ifdef SD_CRC7_EN
               crc_d     = 7'h00;
`else
               crc_d     = crc7_table(cmd.index);
`endif
               resp_d    = '1;
               timeout_d = 1'b0;
               cnt_d     = CNT_W'(PRE_IDLE - 1);
               state_d   = S_PRE;
            end
         end
         S_PRE: begin
            if (cnt_q == '0) begin
               cnt_d   = CNT_W'(47);
               state_d = S_SEND;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_SEND: begin
            // header bits feed the CRC as they leave; then the CRC itself shifts out
            if (cnt_q >= CNT_W'(8)) begin
               tx_d = {tx_q[38:0], 1'b1};
`ifdef SD_CRC7_EN
               crc_d = crc7_step(crc_q, tx_q[39]);
`endif
            end else if (cnt_q != '0) begin
               crc_d = {crc_q[5:0], 1'b1};
            end
            if (cnt_q == '0) begin
               cnt_d   = CNT_W'(RESP_TIMEOUT - 1);
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_WAIT: begin
            if (!DO) begin
               shift_d = {shift_q[38:0], DO};
               cnt_d   = long_q ? CNT_W'(38) : CNT_W'(6);
               state_d = S_RECV;
            end else if (cnt_q == '0) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RECV: begin
            shift_d = {shift_q[38:0], DO};
            if (cnt_q == '0) begin
               resp_d  = long_q ? shift_d : {32'hFFFF_FFFF, shift_d[7:0]};
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE: begin
            if (!cmd.start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         tx_q      <= '1;
         crc_q     <= '1;
         long_q    <= 1'b0;
         shift_q   <= '1;
         resp_q    <= '1;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tx_q      <= tx_d;
         crc_q     <= crc_d;
         long_q    <= long_d;
         shift_q   <= shift_d;
         resp_q    <= resp_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      send_bit = 1'b1;
      if (cnt_q >= CNT_W'(8))  send_bit = tx_q[39];
      else if (cnt_q != '0)    send_bit = crc_q[6];
   end

   // DI is decoded from state so an async reset forces it high without a clock
   assign DI           = (state_q == S_SEND) ? send_bit : 1'b1;
   assign cmd.busy     = (state_q == S_PRE) || (state_q == S_SEND) ||
                         (state_q == S_WAIT) || (state_q == S_RECV);
   assign cmd.finish   = (state_q == S_DONE);
   assign cmd.timeout  = timeout_q;
   assign cmd.response = resp_q;

endmodule

// File: tb/tb_sd_spi_cmd_resp.sv
// Bench for sd_spi_cmd_resp: per-cycle comparison against a timeline model of one command transaction.
module tb_sd_spi_cmd_resp;
   localparam int PRE_IDLE     = 8;
   localparam int RESP_TIMEOUT = 100;
   localparam int SEND0        = PRE_IDLE + 1;
   localparam int WAIT0        = PRE_IDLE + 49;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic DO = 1'b1;
   logic DI;

   sd_spi_cmd_resp_if cif();

   sd_spi_cmd_resp #(.PRE_IDLE(PRE_IDLE), .RESP_TIMEOUT(RESP_TIMEOUT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .cmd     (cif),
      .DI      (DI),
      .DO      (DO)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // model of the transaction in flight, expressed as a timeline relative to the accept edge
   bit          m_active = 1'b0;
   int          m_acc, m_done, m_drop;
   logic [47:0] m_frame;
   logic [39:0] m_resp;
   logic        m_to;
   logic [39:0] last_resp = '1;
   logic        last_to   = 1'b0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
      end
   endfunction

   function automatic logic [6:0] model_crc(input logic [5:0] idx, input logic [31:0] arg);
`ifdef SD_CRC7_EN
      logic [46:0] v;
      v = {2'b01, idx, arg, 7'b0};
      for (int i = 46; i >= 7; i--)
         if (((v >> i) & 47'd1) != 47'd0) v = v ^ (47'h89 << (i - 7));
      return v[6:0];
`else
      if (arg == arg && idx == 6'd0) return 7'h4A;
      if (idx == 6'd8) return 7'h43;
      return 7'h7F;
`endif
   endfunction

   int          c_rel, c_end;
   logic        e_busy, e_fin, e_di, e_to;
   logic [39:0] e_resp;
   logic [47:0] c_sh;

   always @(negedge clk) begin
      if (reset_n) begin
         e_busy = 1'b0; e_fin = 1'b0; e_di = 1'b1; e_resp = last_resp; e_to = last_to;
         if (m_active) begin
            c_rel = cyc - m_acc;
            c_end = (m_drop > m_done) ? m_drop : m_done;
            if (c_rel >= 1 && c_rel < m_done) begin
               e_busy = 1'b1; e_resp = '1; e_to = 1'b0;
               if (c_rel >= SEND0 && c_rel < SEND0 + 48) begin
                  c_sh = m_frame << (c_rel - SEND0);
                  e_di = c_sh[47];
               end
            end else if (c_rel >= m_done) begin
               e_resp = m_resp; e_to = m_to;
               e_fin  = (c_rel <= c_end);
            end
         end
         check("busy",     64'(cif.busy),     64'(e_busy));
         check("finish",   64'(cif.finish),   64'(e_fin));
         check("DI",       64'(DI),           64'(e_di));
         check("timeout",  64'(cif.timeout),  64'(e_to));
         check("response", 64'(cif.response), 64'(e_resp));
      end
   end

   // w >= RESP_TIMEOUT means the card never answers; drop < 0 releases start at rel=-drop,
   // drop >= 0 holds start that many cycles into DONE
   task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input int w,
                          input logic [39:0] r, input int drop,
                          output logic [47:0] di_cap, output int first_fin);
      int n, rel, plan, end_rel;
      logic [39:0] t;
      bit lng;
      lng = (idx == 6'd8) || (idx == 6'd58);
      n   = lng ? 40 : 8;
      @(negedge clk); #1;
      cif.index = idx; cif.argument = arg; cif.start = 1'b1;
      m_frame = {2'b01, idx, arg, model_crc(idx, arg), 1'b1};
      if (w >= RESP_TIMEOUT) begin
         m_done = WAIT0 + RESP_TIMEOUT; m_resp = '1; m_to = 1'b1;
      end else begin
         m_done = WAIT0 + w + n;
         m_resp = lng ? r : {32'hFFFF_FFFF, r[7:0]};
         m_to   = 1'b0;
      end
      plan     = (drop < 0) ? -drop : m_done + drop;
      m_drop   = 1 << 30;
      m_acc    = cyc;
      m_active = 1'b1;
      di_cap   = '0;
      first_fin = -1;
      end_rel  = ((plan > m_done) ? plan : m_done) + 2;
      for (int k = 0; k < 600; k++) begin
         @(posedge clk); #1;
         rel = cyc - m_acc;
         if (rel < WAIT0) DO = 1'($urandom);
         else if (w >= RESP_TIMEOUT || rel - WAIT0 < w) DO = 1'b1;
         else if (rel - WAIT0 - w < n) begin
            t  = r << (40 - n + (rel - WAIT0 - w));
            DO = t[39];
         end else DO = 1'b1;
         @(negedge clk); #1;
         if (rel >= SEND0 && rel < SEND0 + 48) di_cap = {di_cap[46:0], DI};
         if (cif.finish && first_fin < 0) first_fin = rel;
         if (rel == 3) begin cif.index = 6'($urandom); cif.argument = $urandom; end
         if (rel == plan) begin cif.start = 1'b0; m_drop = rel; end
         if (rel >= end_rel) break;
      end
      last_resp = m_resp;
      last_to   = m_to;
      m_active  = 1'b0;
   endtask

   logic [47:0] cap;
   int          ff;
   logic [5:0]  r_idx;
   logic [39:0] r_resp;
   int          r_w, r_drop;

   initial begin
      cif.start = 1'b0; cif.index = '0; cif.argument = '0;
      #12;
      check("rst_busy",     64'(cif.busy),     64'd0);
      check("rst_finish",   64'(cif.finish),   64'd0);
      check("rst_timeout",  64'(cif.timeout),  64'd0);
      check("rst_DI",       64'(DI),           64'd1);
      check("rst_response", 64'(cif.response), 64'hFF_FFFF_FFFF);
      #11 reset_n = 1'b1;

      // CMD0, R1 0x01 three samples into WAIT
      run_txn(6'd0, 32'h0, 3, 40'h01, 2, cap, ff);
      check("cmd0_frame", 64'(cap), 64'h4000_0000_0095);
      check("cmd0_fin_rel", 64'(ff), 64'd68);
      check("cmd0_resp", 64'(cif.response), 64'hFF_FFFF_FF01);
      check("cmd0_to", 64'(cif.timeout), 64'd0);

      // CMD8, long R7 reply, start released while busy
      run_txn(6'd8, 32'h1AA, 5, 40'h01_0000_01AA, -20, cap, ff);
      check("cmd8_frame", 64'(cap), 64'h4800_0001_AA87);
      check("cmd8_fin_rel", 64'(ff), 64'd102);
      check("cmd8_resp", 64'(cif.response), 64'h01_0000_01AA);

      // CMD55, response start bit on the very first WAIT sample
      run_txn(6'd55, 32'h0, 0, 40'h01, 1, cap, ff);
`ifdef SD_CRC7_EN
      check("cmd55_frame", 64'(cap), 64'h7700_0000_0065);
`else
      check("cmd55_frame", 64'(cap), 64'h7700_0000_00FF);
`endif
      check("cmd55_fin_rel", 64'(ff), 64'd57 + 64'd8);
      check("cmd55_resp", 64'(cif.response), 64'hFF_FFFF_FF01);

      // no response at all
      run_txn(6'd17, 32'h1234_5678, RESP_TIMEOUT, 40'h0, 0, cap, ff);
      check("to_fin_rel", 64'(ff), 64'd157);
      check("to_flag", 64'(cif.timeout), 64'd1);
      check("to_resp", 64'(cif.response), 64'hFF_FFFF_FFFF);

      // start held through DONE, then a fresh transaction
      run_txn(6'd1, 32'h0, 10, 40'h00, 6, cap, ff);
      check("hold_fin_rel", 64'(ff), 64'd75);
      run_txn(6'd1, 32'h0, 99, 40'h05, 0, cap, ff);
      check("again_fin_rel", 64'(ff), 64'd164);
      check("again_resp", 64'(cif.response), 64'hFF_FFFF_FF05);

      // async reset in the middle of SEND
      @(negedge clk); #1;
      cif.index = 6'd0; cif.argument = 32'h0; cif.start = 1'b1;
      m_frame = {2'b01, 6'd0, 32'h0, model_crc(6'd0, 32'h0), 1'b1};
      m_done = 1 << 30; m_drop = 1 << 30; m_resp = '1; m_to = 1'b0;
      m_acc = cyc; m_active = 1'b1;
      for (int k = 0; k < 20; k++) @(posedge clk);
      #3;
      check("pre_rst_DI", 64'(DI), 64'd0);
      check("pre_rst_busy", 64'(cif.busy), 64'd1);
      reset_n = 1'b0; cif.start = 1'b0;
      m_active = 1'b0; last_resp = '1; last_to = 1'b0;
      #1;
      check("mid_rst_DI", 64'(DI), 64'd1);
      check("mid_rst_busy", 64'(cif.busy), 64'd0);
      check("mid_rst_finish", 64'(cif.finish), 64'd0);
      check("mid_rst_response", 64'(cif.response), 64'hFF_FFFF_FFFF);
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      run_txn(6'd0, 32'h0, 7, 40'h01, 0, cap, ff);
      check("post_rst_frame", 64'(cap), 64'h4000_0000_0095);

      // randomized transactions
      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 3))
            0:       r_idx = 6'd8;
            1:       r_idx = 6'd58;
            default: r_idx = 6'($urandom);
         endcase
         r_w = ($urandom_range(0, 7) == 0) ? RESP_TIMEOUT : int'($urandom_range(0, 99));
         if (r_idx == 6'd8 || r_idx == 6'd58) r_resp = {1'b0, 7'($urandom), 32'($urandom)};
         else                                 r_resp = {32'h0, 1'b0, 7'($urandom)};
         r_drop = ($urandom_range(0, 1) == 0) ? -int'($urandom_range(1, 50)) : int'($urandom_range(0, 4));
         run_txn(r_idx, $urandom, r_w, r_resp, r_drop, cap, ff);
         check("rand_frame", 64'(cap), 64'(m_frame));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
